// File: rtl/frecuenciometro_param.sv
// Gated edge counter: synchronised rising edges of pin_in accumulate in a saturating BCD counter, published
// one cycle after each G-cycle gate and decoded to active-low 7-segment digits; no backpressure, free-running.
module frecuenciometro_param #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_DIGITS    = 6,
  parameter int SYNC_STAGES = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pin_in,
  input  logic [1:0]            range_sel,
  input  logic                  hold,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [7*N_DIGITS-1:0] disp,
  output logic                  overflow,
  output logic                  meas_valid
);
  localparam int TW = $clog2(CLK_HZ + 1);
  localparam logic [TW-1:0] LAST_1S    = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] LAST_100MS = TW'(CLK_HZ / 10 - 1);
  localparam logic [TW-1:0] LAST_10MS  = TW'(CLK_HZ / 100 - 1);

  localparam logic [1:0] S_GATE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [1:0]             r_range;
  logic [1:0]             r_state;
  logic [TW-1:0]          r_timer;
  logic [4*N_DIGITS-1:0]  r_cnt;
  logic                   r_ovf;
  logic [4*N_DIGITS-1:0]  r_bcd;
  logic                   r_overflow;
  logic                   r_valid;

  logic                   w_edge;
  logic                   w_abort;
  logic                   w_gate_end;
  logic                   w_all9;
  logic [TW-1:0]          w_last;
  logic [N_DIGITS-1:0]    w_is9;
  logic [N_DIGITS-1:0]    w_nz;
  logic [N_DIGITS-1:0]    w_lit;
  logic [4*N_DIGITS-1:0]  w_cnt_inc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_comb begin
    case (r_range)
      2'b01:   w_last = LAST_100MS;
      2'b10:   w_last = LAST_10MS;
      default: w_last = LAST_1S;
    endcase
  end

  // Any raw change of range_sel while gating restarts the measurement with the new gate.
  assign w_abort    = (r_state == S_GATE) && (range_sel != r_range);
  assign w_gate_end = (r_state == S_GATE) && (r_timer == w_last);
  assign w_all9     = &w_is9;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam logic [N_DIGITS-1:0] LOW = N_DIGITS'((1 << k) - 1);
    logic w_carry;

    assign w_is9[k] = (r_cnt[4*k +: 4] == 4'd9);
    assign w_carry  = &(w_is9 | ~LOW);
    assign w_cnt_inc[4*k +: 4] = !w_carry ? r_cnt[4*k +: 4] :
                                 (w_is9[k] ? 4'd0 : r_cnt[4*k +: 4] + 4'd1);

    assign w_nz[k]  = |r_bcd[4*k +: 4];
    assign w_lit[k] = (BLANK_LZ == 0) || (k == 0) || (|(w_nz & ~LOW));
    assign disp[7*k +: 7] = r_overflow ? 7'b1111110 :
                            (!w_lit[k] ? 7'b1111111 : seg7(r_bcd[4*k +: 4]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_range    <= 2'b00;
      r_state    <= S_GATE;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pin_in};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_range <= range_sel;
      r_valid <= 1'b0;
      case (r_state)
        S_GATE: begin
          if (w_abort) begin
            r_timer <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end else begin
            if (w_edge) begin
              if (w_all9) r_ovf <= 1'b1;
              else        r_cnt <= w_cnt_inc;
            end
            if (w_gate_end) begin
              r_timer <= '0;
              r_state <= S_LATCH;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        S_LATCH: begin
          if (!hold) begin
            r_bcd      <= r_cnt;
            r_overflow <= r_ovf;
            r_valid    <= 1'b1;
          end
          r_state <= S_CLEAR;
        end
        default: begin
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
          r_state <= S_GATE;
        end
      endcase
    end
  end

  assign bcd_out    = r_bcd;
  assign overflow   = r_overflow;
  assign meas_valid = r_valid;

endmodule
